// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// the FSM state encoding and the legal upper bound for the result width.
package sar_pkg;

   // Widest result the controller supports; checked at elaboration.
   localparam int SAR_MAX_N = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRIAL = 2'd1,
      ST_DONE  = 2'd2
   } sar_state_t;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller. Drives trial values into an
// external "sample < trial" comparator, resolving an N-bit value MSB first,
// and presents the converged value on a valid/ready output.
// Optional build macro SAR_CMP_REG_EN: register the comparator answer and
// spend two TRIAL cycles per bit (drive, then decide on the registered answer).
module sar_search
   import sar_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start_valid,
   output logic         start_ready,
   output logic [N-1:0] trial,
   input  logic         cmp_lt,
   output logic         busy,
   output logic [N-1:0] result,
   output logic         result_valid,
   input  logic         result_ready
);

   // Bit pointer width; a 1-bit result still needs a 1-bit pointer.
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] LSB_ONE = N'(1'b1);

   generate
      if (N < 1 || N > SAR_MAX_N) begin : g_bad_width
         $error("sar_search: parameter N out of range");
      end
   endgenerate

   sar_state_t      state_q, state_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [PW-1:0]   bit_q, bit_d;
   logic [N-1:0]    trial_q, trial_d;
   logic [N-1:0]    result_q, result_d;

   logic [N-1:0]    mask_s;
   logic [N-1:0]    acc_new_s;
   logic            decide_s;
   logic            cmp_use_s;

`ifdef SAR_CMP_REG_EN
   logic            cmp_q, cmp_d;
   logic            phase_q, phase_d;

   // Phase alternates drive/decide within TRIAL; comparator answer is captured every cycle.
   always_comb begin
      cmp_d = cmp_lt;
      if (state_q == ST_TRIAL) begin
         phase_d = ~phase_q;
      end else begin
         phase_d = 1'b0;
      end
   end

   // Registered comparator answer and phase flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_q   <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         cmp_q   <= cmp_d;
         phase_q <= phase_d;
      end
   end

   assign decide_s  = phase_q;
   assign cmp_use_s = cmp_q;
`else
   assign decide_s  = 1'b1;
   assign cmp_use_s = cmp_lt;
`endif

   // Next-state, accumulator and trial computation for the search.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      bit_d    = bit_q;
      trial_d  = trial_q;
      result_d = result_q;

      mask_s    = LSB_ONE << bit_q;
      // Keep the tentative bit only when the trial did not exceed the sample.
      acc_new_s = cmp_use_s ? acc_q : (acc_q | mask_s);

      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               state_d = ST_TRIAL;
               acc_d   = '0;
               bit_d   = PW'(N - 1);
               trial_d = LSB_ONE << PW'(N - 1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TRIAL: begin
            if (decide_s) begin
               acc_d = acc_new_s;
               if (bit_q == '0) begin
                  state_d  = ST_DONE;
                  trial_d  = acc_new_s;
                  result_d = acc_new_s;
               end else begin
                  bit_d   = bit_q - PW'(1'b1);
                  trial_d = acc_new_s | (mask_s >> 1);
               end
            end else begin
               acc_d = acc_q;
            end
         end
         ST_DONE: begin
            if (result_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, accumulator, pointer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         bit_q    <= '0;
         trial_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         bit_q    <= bit_d;
         trial_q  <= trial_d;
         result_q <= result_d;
      end
   end

   assign trial        = trial_q;
   assign result       = result_q;
   assign start_ready  = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign result_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: an N=8 instance driven through directed and random
// conversions with a scoreboard monitor, plus an N=1 instance.
module tb_sar_search;

   localparam int N = 8;
`ifdef SAR_CMP_REG_EN
   localparam int CPB = 2;
`else
   localparam int CPB = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         rst, start_valid, result_ready;
   logic         start_ready, busy, result_valid, cmp_lt;
   logic [N-1:0] trial, result, sample;

   // Comparator: a = sample, b = trial.
   assign cmp_lt = (sample < trial);

   sar_search #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .trial(trial), .cmp_lt(cmp_lt), .busy(busy),
      .result(result), .result_valid(result_valid), .result_ready(result_ready)
   );

   logic       s1_start_valid, s1_start_ready, s1_busy, s1_result_valid, s1_result_ready;
   logic [0:0] s1_trial, s1_result, s1_sample;
   logic       s1_cmp_lt;
   assign s1_cmp_lt = (s1_sample < s1_trial);

   sar_search #(.N(1)) dut1 (
      .clk(clk), .rst(rst),
      .start_valid(s1_start_valid), .start_ready(s1_start_ready),
      .trial(s1_trial), .cmp_lt(s1_cmp_lt), .busy(s1_busy),
      .result(s1_result), .result_valid(s1_result_valid), .result_ready(s1_result_ready)
   );

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_q[$];
   int           start_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every presented result against the scoreboard head.
   initial begin : monitor
      bit seen;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 1'b0;
         end else if (result_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got 0x%0h with nothing expected", result);
            end else begin
               check("result", result, exp_q[0]);
               if (!seen) begin
                  check("latency", cyc - start_q[0], N * CPB + 1);
                  seen = 1'b1;
               end
               if (result_ready) begin
                  void'(exp_q.pop_front());
                  void'(start_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   // Reference: binary search over [0, 2^N) by halving step sizes.
   task automatic start_conv(input logic [N-1:0] s);
      int lo, step;
      logic [N-1:0] tr[N];
      lo = 0;
      for (int b = 0; b < N; b++) begin
         step  = 1 << (N - 1 - b);
         tr[b] = N'(lo + step);
         if (lo + step <= int'(s)) lo = lo + step;
      end
      @(posedge clk); #1;
      sample      = s;
      start_valid = 1'b1;
      @(negedge clk);
      check("start_ready", start_ready, 1);
      exp_q.push_back(N'(lo));
      start_q.push_back(cyc);
      @(posedge clk); #1;
      start_valid = 1'b0;
      for (int b = 0; b < N; b++) begin
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            check("trial", trial, tr[b]);
         end
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (k < 200 && !(start_ready && exp_q.size() == 0)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         checks++;
         errors++;
         $display("FAIL timeout: conversion did not complete within 200 cycles");
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [N-1:0] rs;
      rst = 1'b1; start_valid = 1'b0; result_ready = 1'b1; sample = '0;
      s1_start_valid = 1'b0; s1_result_ready = 1'b1; s1_sample = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_trial", trial, 0);
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_start_ready", start_ready, 1);

      // Directed values including both boundaries.
      start_conv(8'hA5); wait_idle();
      start_conv(8'h00); wait_idle();
      start_conv(8'hFF); wait_idle();

      // Random conversions.
      for (int i = 0; i < 8; i++) begin
         rs = N'($urandom_range(0, 255));
         start_conv(rs);
         wait_idle();
      end

      // Backpressure with an ignored start pulse during DONE.
      result_ready = 1'b0;
      start_conv(8'h5A);
      @(posedge clk); #1;
      start_valid = 1'b1;
      @(negedge clk);
      check("bp_start_ready", start_ready, 0);
      check("bp_valid", result_valid, 1);
      @(posedge clk); #1;
      start_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid_hold", result_valid, 1);
         check("bp_busy", busy, 1);
      end
      @(posedge clk); #1;
      result_ready = 1'b1;
      @(negedge clk);
      check("hs_start_ready", start_ready, 0);
      @(negedge clk);
      check("post_hs_start_ready", start_ready, 1);
      check("post_hs_valid", result_valid, 0);
      check("post_hs_busy", busy, 0);

      // Reset during TRIAL cycle 4 aborts the conversion.
      @(posedge clk); #1;
      sample = 8'h77; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_trial", trial, 0);
      check("abort_valid", result_valid, 0);
      check("abort_start_ready", start_ready, 1);
      check("abort_busy", busy, 0);
      start_conv(8'h3C); wait_idle();

      // Single-bit instance.
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); #1;
         s1_sample = 1'(s); s1_start_valid = 1'b1;
         @(posedge clk); #1;
         s1_start_valid = 1'b0;
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            check("n1_trial", s1_trial, 1);
            check("n1_valid_low", s1_result_valid, 0);
         end
         @(negedge clk);
         check("n1_valid", s1_result_valid, 1);
         check("n1_result", s1_result, s);
         @(negedge clk);
         check("n1_start_ready", s1_start_ready, 1);
      end

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
